sys_feed_ctrl: RTL

//  Sequencer for the systolic-array input queues. On start, it streams data and weight words from SRAM

---
 rtl/sys_feed_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sys_feed_ctrl.sv
`default_nettype none
// ============================================================================
// sys_feed_ctrl : loads 2*ARRAY_SIZE input FIFOs from SRAM, then feeds the
// systolic array with row skew and pulses done. Optional macro: PERF_CNT_EN.
// Rev 1.0
// ============================================================================
module sys_feed_ctrl #(
   parameter int ARRAY_SIZE = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 16,
   parameter int DRAIN_CYC  = 2 * ARRAY_SIZE
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_i,
   input  logic                    abort_i,
   input  logic [ADDR_W-1:0]       base_addr_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o,
   output logic                    sram_rd_en_o,
   output logic [ADDR_W-1:0]       sram_addr_o,
   input  logic [DATA_W-1:0]       sram_rdata_i,
   output logic [DATA_W-1:0]       fifo_wdata_o,
   output logic [2*ARRAY_SIZE-1:0] fifo_wr_en_o,
   input  logic [2*ARRAY_SIZE-1:0] fifo_full_i,
   input  logic                    compute_rdy_i,
   output logic [ARRAY_SIZE-1:0]   fifo_rd_en_o,
   output logic [31:0]             perf_cycles_o
);

   localparam int c_n_fifo  = 2 * ARRAY_SIZE;
   localparam int c_n_words = c_n_fifo * FIFO_DEPTH;
   localparam int c_w_w     = (c_n_words > 1) ? $clog2(c_n_words) : 1;
   localparam int c_sel_w   = (c_n_fifo > 1) ? $clog2(c_n_fifo) : 1;
   localparam int c_t_max   = FIFO_DEPTH + ARRAY_SIZE - 2;
   localparam int c_t_w     = (c_t_max > 0) ? $clog2(c_t_max + 1) : 1;
   localparam int c_d_w     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   localparam logic [c_w_w-1:0]    c_w_last = c_w_w'(c_n_words - 1);
   localparam logic [c_t_w-1:0]    c_t_last = c_t_w'(c_t_max);
   localparam logic [c_d_w-1:0]    c_d_last = c_d_w'(DRAIN_CYC - 1);
   localparam logic [c_n_fifo-1:0] c_one    = c_n_fifo'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;
   logic                rd_en_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [c_w_w-1:0]    w_q;
   logic                wr_valid_q;
   logic [c_sel_w-1:0]  wr_sel_q;
   logic [c_sel_w-1:0]  wr_sel_d;
   logic [c_t_w-1:0]    t_q;
   logic [c_d_w-1:0]    d_q;

   // Target FIFO of the word being issued; it is written one cycle later.
   assign wr_sel_d = c_sel_w'(int'(w_q) / FIFO_DEPTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rd_en_q    <= 1'b0;
         addr_q     <= '0;
         w_q        <= '0;
         wr_valid_q <= 1'b0;
         wr_sel_q   <= '0;
         t_q        <= '0;
         d_q        <= '0;
      end else if (abort_i) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         addr_q     <= '0;
         w_q        <= '0;
         wr_valid_q <= 1'b0;
         wr_sel_q   <= '0;
         t_q        <= '0;
         d_q        <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q    <= S_LOAD;
                  busy_q     <= 1'b1;
                  err_q      <= 1'b0;
                  rd_en_q    <= 1'b1;
                  addr_q     <= base_addr_i;
                  w_q        <= '0;
                  wr_valid_q <= 1'b0;
               end
            end
            S_LOAD: begin
               wr_valid_q <= rd_en_q;
               if (wr_valid_q && fifo_full_i[wr_sel_q]) begin
                  err_q <= 1'b1;
               end
               if (rd_en_q) begin
                  wr_sel_q <= wr_sel_d;
                  if (w_q == c_w_last) begin
                     rd_en_q <= 1'b0;
                  end else begin
                     w_q    <= w_q + c_w_w'(1);
                     addr_q <= addr_q + ADDR_W'(1);
                  end
               end else begin
                  // Issue finished last cycle and the final write lands now.
                  state_q <= S_FEED;
                  t_q     <= '0;
               end
            end
            S_FEED: begin
               if (compute_rdy_i) begin
                  if (t_q == c_t_last) begin
                     state_q <= S_DRAIN;
                     d_q     <= '0;
                  end else begin
                     t_q <= t_q + c_t_w'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (d_q == c_d_last) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  d_q <= d_q + c_d_w'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      fifo_wr_en_o = '0;
      if (wr_valid_q && !abort_i) begin
         fifo_wr_en_o = (c_one << wr_sel_q) & ~fifo_full_i;
      end
   end

   // Row i is active on beats i .. i+FIFO_DEPTH-1, giving the diagonal skew.
   always_comb begin
      fifo_rd_en_o = '0;
      if (state_q == S_FEED && compute_rdy_i && !abort_i) begin
         for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (int'(t_q) >= i && int'(t_q) < i + FIFO_DEPTH) begin
               fifo_rd_en_o[i] = 1'b1;
            end
         end
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign sram_rd_en_o = rd_en_q;
   assign sram_addr_o  = addr_q;
   assign fifo_wdata_o = sram_rdata_i;

`ifdef PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else if (state_q == S_IDLE && start_i && !abort_i) begin
         perf_q <= '0;
      end else if (state_q != S_IDLE && state_q != S_DONE && perf_q != 32'hFFFF_FFFF) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_cycles_o = perf_q;
`else
   assign perf_cycles_o = '0;
`endif

endmodule
`default_nettype wire
